// File: rtl/signed_acc_pkg.sv
// Shared types, default widths and the product sign-extension helper for signed_accumulator.
// The saturating variant is selected with SIGNED_ACC_SATURATE_EN (see acc_saturate).
package signed_acc_pkg;

    localparam int PROD_W_DEF = 16;
    localparam int ACC_W_DEF  = 24;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_e;

    // Sign-extend the low w bits of p to 64 bits; callers truncate to their own width.
    function automatic logic [63:0] sext_prod(input logic [63:0] p, input int w);
        logic signed [63:0] t;
        t = signed'(p << (64 - w));
        return t >>> (64 - w);
    endfunction

endpackage

// File: rtl/acc_saturate.sv
// Reduces the ACC_W+1-bit running sum to ACC_W bits.
// With SIGNED_ACC_SATURATE_EN it clamps to the signed range and flags overflow; otherwise it wraps.
module acc_saturate #(
    parameter int ACC_W = 24
) (
    input  logic [ACC_W:0]   sum_i,
    output logic [ACC_W-1:0] acc_o,
    output logic             ovf_o
);

`ifdef SIGNED_ACC_SATURATE_EN
    // The extra sign bit disagreeing with the ACC_W sign bit means the result left the range.
    always_comb begin
        ovf_o = sum_i[ACC_W] ^ sum_i[ACC_W-1];
        acc_o = sum_i[ACC_W-1:0];
        if (ovf_o) begin
            acc_o = sum_i[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    logic unused_msb;
    assign unused_msb = sum_i[ACC_W];
    assign acc_o      = sum_i[ACC_W-1:0];
    assign ovf_o      = 1'b0;
`endif

endmodule

// File: rtl/signed_accumulator.sv
// Accumulates a valid/ready stream of signed products into one dot-product result per prod_last.
// Overflow behaviour (wrap vs clamp + sticky flag) follows SIGNED_ACC_SATURATE_EN.
module signed_accumulator
    import signed_acc_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod_data,
    input  logic              prod_last,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [ACC_W-1:0]  acc_data,
    output logic [CNT_W-1:0]  acc_count,
    output logic              acc_ovf
);

    acc_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             beat, take, first;
    logic [ACC_W:0]   prod_x, sum;
    logic [ACC_W-1:0] sat_acc;
    logic             sat_ovf;

    assign acc_valid  = (state_q == HOLD);
    assign prod_ready = (state_q != HOLD) | acc_ready;
    assign beat       = prod_valid & prod_ready;
    assign take       = acc_valid & acc_ready;
    // A beat outside ACCUM always opens a new sum (from HOLD it only lands while the result is taken).
    assign first      = (state_q != ACCUM);

    assign prod_x = (ACC_W+1)'(sext_prod(64'(prod_data), PROD_W));
    assign sum    = {acc_q[ACC_W-1], acc_q} + prod_x;

    acc_saturate #(.ACC_W(ACC_W)) u_sat (
        .sum_i (sum),
        .acc_o (sat_acc),
        .ovf_o (sat_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (beat) begin
            if (first) begin
                acc_d = prod_x[ACC_W-1:0];
                cnt_d = CNT_W'(1);
                ovf_d = 1'b0;
            end else begin
                acc_d = sat_acc;
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                ovf_d = ovf_q | sat_ovf;
            end
            state_d = prod_last ? HOLD : ACCUM;
        end else if (take) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign acc_data  = acc_q;
    assign acc_count = cnt_q;
    assign acc_ovf   = ovf_q;

endmodule

// File: tb/tb_signed_accumulator.sv
// Directed-vector and throttled-stream bench for signed_accumulator (default widths plus an ACC_W=18 copy).
// Overflow expectations follow SIGNED_ACC_SATURATE_EN as defined for the build.
module tb_signed_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prod_valid = 1'b0, prod_last = 1'b0, acc_ready = 1'b0;
    logic [15:0] prod_data = '0;
    logic        prod_ready, acc_valid, acc_ovf;
    logic [23:0] acc_data;
    logic [7:0]  acc_count;

    logic        s_prod_valid = 1'b0, s_prod_last = 1'b0, s_acc_ready = 1'b0;
    logic [15:0] s_prod_data = '0;
    logic        s_prod_ready, s_acc_valid, s_acc_ovf;
    logic [17:0] s_acc_data;
    logic [7:0]  s_acc_count;

    int n_vec = 0;
    int n_mis = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    signed_accumulator dut (
        .clk(clk), .rst(rst),
        .prod_valid(prod_valid), .prod_ready(prod_ready), .prod_data(prod_data), .prod_last(prod_last),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data), .acc_count(acc_count),
        .acc_ovf(acc_ovf)
    );

    signed_accumulator #(.PROD_W(16), .ACC_W(18), .CNT_W(8)) dut_s (
        .clk(clk), .rst(rst),
        .prod_valid(s_prod_valid), .prod_ready(s_prod_ready), .prod_data(s_prod_data),
        .prod_last(s_prod_last), .acc_valid(s_acc_valid), .acc_ready(s_acc_ready),
        .acc_data(s_acc_data), .acc_count(s_acc_count), .acc_ovf(s_acc_ovf)
    );

    typedef struct {
        string  name;
        int     n;
        int     d[6];
        longint exp_sum;
        int     exp_cnt;
    } vec_t;

    typedef struct {
        longint sum;
        int     cnt;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic last);
        prod_valid = 1'b1;
        prod_data  = 16'(d);
        prod_last  = last;
        tick();
        prod_valid = 1'b0;
        prod_last  = 1'b0;
    endtask

    task automatic take_result();
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        chk("taken_valid_low", acc_valid, 0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{"mixed3",   3, '{-3, 10, -20, 0, 0, 0},               -13,    3};
        vecs[1] = '{"single",   1, '{-16384, 0, 0, 0, 0, 0},              -16384, 1};
        vecs[2] = '{"pair",     2, '{3, 4, 0, 0, 0, 0},                   7,      2};
        vecs[3] = '{"maxpos4",  4, '{32767, 32767, 32767, 32767, 0, 0},   131068, 4};
        vecs[4] = '{"minneg2",  2, '{-32768, -32768, 0, 0, 0, 0},         -65536, 2};
        vecs[5] = '{"cancel3",  3, '{100, -100, 5, 0, 0, 0},              5,      3};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", acc_valid, 0);
        chk("rst_data", acc_data, 0);
        chk("rst_count", acc_count, 0);
        chk("rst_ovf", acc_ovf, 0);
        chk("rst_ready", prod_ready, 1);
        @(negedge clk) rst = 1'b0;
        tick();

        // table-driven sums
        foreach (vecs[i]) begin
            for (int j = 0; j < vecs[i].n; j++) begin
                if (j == vecs[i].n - 1) chk({vecs[i].name, "_pre_valid"}, acc_valid, 0);
                send(vecs[i].d[j], j == vecs[i].n - 1);
            end
            chk({vecs[i].name, "_valid"}, acc_valid, 1);
            chk({vecs[i].name, "_data"}, longint'($signed(acc_data)), vecs[i].exp_sum);
            chk({vecs[i].name, "_count"}, acc_count, vecs[i].exp_cnt);
            chk({vecs[i].name, "_ovf"}, acc_ovf, 0);
            take_result();
        end

        // async reset mid-sum
        send(5, 1'b0);
        send(7, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", acc_valid, 0);
        chk("midrst_data", acc_data, 0);
        chk("midrst_count", acc_count, 0);
        chk("midrst_ovf", acc_ovf, 0);
        @(negedge clk) rst = 1'b0;
        tick();
        send(3, 1'b0);
        send(4, 1'b1);
        chk("postrst_data", longint'($signed(acc_data)), 7);
        chk("postrst_count", acc_count, 2);
        take_result();

        // back-pressure hold, then zero-bubble hand-over
        send(1, 1'b0);
        send(2, 1'b1);
        prod_valid = 1'b1;
        prod_data  = 16'(9);
        prod_last  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("hold_ready", prod_ready, 0);
            chk("hold_valid", acc_valid, 1);
            chk("hold_data", longint'($signed(acc_data)), 3);
            chk("hold_count", acc_count, 2);
            tick();
        end
        acc_ready = 1'b1;
        #1;
        chk("handover_ready", prod_ready, 1);
        tick();
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        chk("handover_valid", acc_valid, 1);
        chk("handover_data", longint'($signed(acc_data)), 9);
        chk("handover_count", acc_count, 1);
        tick();
        acc_ready = 1'b0;
        chk("handover_drained", acc_valid, 0);

        // term counter saturation
        for (int k = 0; k < 260; k++) send(1, k == 259);
        chk("cntsat_data", longint'($signed(acc_data)), 260);
        chk("cntsat_count", acc_count, 255);
        take_result();

        // narrow accumulator overflow
        for (int k = 0; k < 9; k++) begin
            s_prod_valid = 1'b1;
            s_prod_data  = 16'(16384);
            s_prod_last  = (k == 8);
            tick();
        end
        s_prod_valid = 1'b0;
        s_prod_last  = 1'b0;
        chk("narrow_valid", s_acc_valid, 1);
        chk("narrow_count", s_acc_count, 9);
`ifdef SIGNED_ACC_SATURATE_EN
        chk("narrow_data", longint'($signed(s_acc_data)), 131071);
        chk("narrow_ovf", s_acc_ovf, 1);
`else
        chk("narrow_data", longint'($signed(s_acc_data)), -114688);
        chk("narrow_ovf", s_acc_ovf, 0);
`endif
        s_acc_ready = 1'b1;
        tick();
        s_acc_ready = 1'b0;
        chk("narrow_taken", s_acc_valid, 0);

        // throttled random stream against a running-sum model
        fork
            begin : producer
                int s = 0, k = 0, len, t0;
                longint sum = 0;
                t0  = cyc;
                len = $urandom_range(1, 6);
                while (s < 200 && cyc - t0 < 20000) begin
                    tick();
                    prod_valid = ($urandom_range(0, 3) != 0);
                    prod_data  = 16'($urandom);
                    prod_last  = (k == len - 1);
                    @(negedge clk);
                    if (prod_valid && prod_ready) begin
                        sum += longint'($signed(prod_data));
                        k++;
                        if (prod_last) begin
                            exp_q.push_back('{sum, k});
                            s++;
                            k   = 0;
                            sum = 0;
                            len = $urandom_range(1, 6);
                        end
                    end
                end
                tick();
                prod_valid = 1'b0;
                prod_last  = 1'b0;
            end
            begin : consumer
                int got = 0, t1;
                exp_t e;
                t1 = cyc;
                while (got < 200 && cyc - t1 < 20000) begin
                    tick();
                    acc_ready = ($urandom_range(0, 2) != 0);
                    @(negedge clk);
                    if (acc_valid && acc_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("rand_unexpected_result", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("rand_data", longint'($signed(acc_data)), e.sum);
                            chk("rand_count", acc_count, e.cnt);
                            chk("rand_ovf", acc_ovf, 0);
                        end
                        got++;
                    end
                end
                tick();
                acc_ready = 1'b0;
                chk("rand_sums_taken", got, 200);
            end
        join
        chk("rand_leftover", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
